// File: rtl/selen_soc_hub.sv
// rtl/selen_soc_hub.sv - Selen SoC uncore: UART boot loader, program/data memories, UART TX register
module selen_soc_hub #(
    parameter int PROG_WORDS = 32,
    parameter int DATA_WORDS = 256
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        cpu_rst_n,
    input  logic        cpu_wbi_cyc,
    input  logic        cpu_wbi_stb,
    input  logic [31:0] cpu_wbi_addr,
    output logic [31:0] cpu_wbi_data,
    output logic        cpu_wbi_ack,
    output logic        cpu_wbi_stall,
    input  logic        cpu_wbd_stb,
    input  logic        cpu_wbd_we,
    input  logic [3:0]  cpu_wbd_be,
    input  logic [31:0] cpu_wbd_addr,
    input  logic [31:0] cpu_wbd_data_o,
    output logic [31:0] cpu_wbd_data_i,
    output logic        cpu_wbd_ack
);
    localparam int PAW = $clog2(PROG_WORDS);
    localparam int DAW = $clog2(DATA_WORDS);
    localparam logic [31:0] TX_DATA_ADDR = 32'h8000_0000;
    localparam logic [31:0] TX_STAT_ADDR = 32'h8000_0004;

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t        rx_state;
    rx_state_t        rx_next;
    logic [2:0]       rx_bit_cnt;
    logic [7:0]       rx_shift;
    logic             rx_byte_valid;

    logic [PAW-1:0]   ld_word;
    logic [1:0]       ld_byte;
    logic [23:0]      ld_buf;
    logic             boot_done;
    logic             ld_word_wr;
    logic [31:0]      prog_mem [PROG_WORDS];

    logic             wbi_accept;
    logic [DAW-1:0]   d_idx;
    logic             ram_sel;
    logic [31:0]      rd_word;
    logic [31:0]      data_ram [DATA_WORDS];

    logic             tx_busy;
    logic             tx_start;
    logic [3:0]       tx_cnt;
    logic [8:0]       tx_shift;

    logic             unused_wbi_addr;
    assign unused_wbi_addr = ^{cpu_wbi_addr[31:PAW+2], cpu_wbi_addr[1:0]};

    // Receiver: one bit per clock, start bit then d7..d0 then stop bit
    always_ff @(posedge sys_clk) begin
        if (!sys_rst) rx_state <= RX_IDLE;
        else          rx_state <= rx_next;
    end

    always_comb begin
        rx_next       = rx_state;
        rx_byte_valid = 1'b0;
        case (rx_state)
            RX_IDLE: if (!uart_rx) rx_next = RX_DATA;
            RX_DATA: if (rx_bit_cnt == 3'd7) rx_next = RX_STOP;
            RX_STOP: begin
                rx_next       = RX_IDLE;
                rx_byte_valid = uart_rx;
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            rx_bit_cnt <= '0;
            rx_shift   <= '0;
        end else if (rx_state == RX_DATA) begin
            rx_bit_cnt <= rx_bit_cnt + 3'd1;
            rx_shift   <= {rx_shift[6:0], uart_rx};
        end else begin
            rx_bit_cnt <= '0;
        end
    end

    // Loader: big-endian byte packing; the 4th byte commits the word
    assign ld_word_wr = rx_byte_valid && !boot_done && (ld_byte == 2'd3);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            ld_word   <= '0;
            ld_byte   <= '0;
            ld_buf    <= '0;
            boot_done <= 1'b0;
        end else if (rx_byte_valid && !boot_done) begin
            ld_byte <= ld_byte + 2'd1;
            ld_buf  <= {ld_buf[15:0], rx_shift};
            if (ld_word_wr) begin
                ld_word <= ld_word + PAW'(1);
                if (ld_word == PAW'(PROG_WORDS - 1)) boot_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst && ld_word_wr) prog_mem[ld_word] <= {ld_buf, rx_shift};
    end

    // Instruction port
    assign cpu_rst_n     = boot_done;
    assign cpu_wbi_stall = !boot_done;
    assign wbi_accept    = cpu_wbi_cyc && cpu_wbi_stb && boot_done;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            cpu_wbi_ack  <= 1'b0;
            cpu_wbi_data <= '0;
        end else begin
            cpu_wbi_ack <= wbi_accept;
            if (wbi_accept) cpu_wbi_data <= prog_mem[cpu_wbi_addr[PAW+1:2]];
        end
    end

    // Data port: RAM below 0x8000_0000, UART TX registers above
    assign d_idx   = cpu_wbd_addr[DAW+1:2];
    assign ram_sel = !cpu_wbd_addr[31];

    always_ff @(posedge sys_clk) begin
        if (sys_rst && cpu_wbd_stb && cpu_wbd_we && ram_sel) begin
            for (int b = 0; b < 4; b++) begin
                if (cpu_wbd_be[b]) data_ram[d_idx][8*b +: 8] <= cpu_wbd_data_o[8*b +: 8];
            end
        end
    end

    always_comb begin
        rd_word = '0;
        if (ram_sel)                            rd_word = data_ram[d_idx];
        else if (cpu_wbd_addr == TX_STAT_ADDR)  rd_word = {31'b0, tx_busy};
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            cpu_wbd_ack    <= 1'b0;
            cpu_wbd_data_i <= '0;
        end else begin
            cpu_wbd_ack <= cpu_wbd_stb;
            if (cpu_wbd_stb && !cpu_wbd_we) cpu_wbd_data_i <= rd_word;
        end
    end

    // Transmitter: start bit leaves in the ack cycle, busy clears after the stop bit
    assign tx_start = cpu_wbd_stb && cpu_wbd_we && cpu_wbd_be[0]
                   && (cpu_wbd_addr == TX_DATA_ADDR) && !tx_busy;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            tx_busy  <= 1'b0;
            uart_tx  <= 1'b1;
            tx_cnt   <= '0;
            tx_shift <= '0;
        end else if (tx_start) begin
            tx_busy  <= 1'b1;
            uart_tx  <= 1'b0;
            tx_cnt   <= '0;
            tx_shift <= {cpu_wbd_data_o[7:0], 1'b1};
        end else if (tx_busy) begin
            if (tx_cnt == 4'd9) begin
                tx_busy <= 1'b0;
                uart_tx <= 1'b1;
            end else begin
                uart_tx  <= tx_shift[8];
                tx_shift <= {tx_shift[7:0], 1'b1};
                tx_cnt   <= tx_cnt + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_selen_soc_hub.sv
// tb/tb_selen_soc_hub.sv - self-checking bench for selen_soc_hub with a transaction-level model
module tb_selen_soc_hub;
    localparam int PW = 32;
    localparam int DW = 256;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        uart_rx;
    logic        uart_tx;
    logic        cpu_rst_n;
    logic        cpu_wbi_cyc;
    logic        cpu_wbi_stb;
    logic [31:0] cpu_wbi_addr;
    logic [31:0] cpu_wbi_data;
    logic        cpu_wbi_ack;
    logic        cpu_wbi_stall;
    logic        cpu_wbd_stb;
    logic        cpu_wbd_we;
    logic [3:0]  cpu_wbd_be;
    logic [31:0] cpu_wbd_addr;
    logic [31:0] cpu_wbd_data_o;
    logic [31:0] cpu_wbd_data_i;
    logic        cpu_wbd_ack;

    selen_soc_hub #(.PROG_WORDS(PW), .DATA_WORDS(DW)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .uart_rx(uart_rx), .uart_tx(uart_tx),
        .cpu_rst_n(cpu_rst_n), .cpu_wbi_cyc(cpu_wbi_cyc), .cpu_wbi_stb(cpu_wbi_stb),
        .cpu_wbi_addr(cpu_wbi_addr), .cpu_wbi_data(cpu_wbi_data), .cpu_wbi_ack(cpu_wbi_ack),
        .cpu_wbi_stall(cpu_wbi_stall), .cpu_wbd_stb(cpu_wbd_stb), .cpu_wbd_we(cpu_wbd_we),
        .cpu_wbd_be(cpu_wbd_be), .cpu_wbd_addr(cpu_wbd_addr), .cpu_wbd_data_o(cpu_wbd_data_o),
        .cpu_wbd_data_i(cpu_wbd_data_i), .cpu_wbd_ack(cpu_wbd_ack)
    );

    always #5 sys_clk = ~sys_clk;

    int checks   = 0;
    int failures = 0;

    // Model state
    bit          chk_en = 1'b0;
    bit          m_in_reset;
    bit          m_boot;
    int          m_nb;
    int          m_word;
    logic [31:0] m_buf;
    logic [31:0] m_prog [PW];
    logic [31:0] m_ram [DW];
    bit          m_ack_i, m_ack_d, m_rd_d;
    logic [31:0] m_dat_i, m_dat_d;
    bit          m_tx = 1'b1;
    bit          m_in_frame;
    bit          tx_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic m_byte(input logic [7:0] b);
        if (!m_boot) begin
            m_buf = {m_buf[23:0], b};
            m_nb++;
            if (m_nb == 4) begin
                m_prog[m_word] = m_buf;
                m_nb = 0;
                if (m_word == PW - 1) m_boot = 1'b1;
                m_word = (m_word + 1) % PW;
            end
        end
    endtask

    // Model: expected outputs for the cycle following each rising edge
    initial begin
        logic [9:0] fr;
        bit         busy;
        int         widx;
        forever begin
            @(posedge sys_clk);
            if (!sys_rst) begin
                chk_en     = 1'b1;
                m_in_reset = 1'b1;
                m_boot     = 1'b0;
                m_nb       = 0;
                m_word     = 0;
                m_buf      = '0;
                m_ack_i    = 1'b0;
                m_ack_d    = 1'b0;
                m_rd_d     = 1'b0;
                m_dat_i    = '0;
                m_dat_d    = '0;
                m_tx       = 1'b1;
                m_in_frame = 1'b0;
                tx_q.delete();
            end else begin
                m_in_reset = 1'b0;
                m_ack_i = cpu_wbi_cyc && cpu_wbi_stb && m_boot;
                if (m_ack_i) m_dat_i = m_prog[int'((cpu_wbi_addr >> 2) % PW)];
                m_ack_d = cpu_wbd_stb;
                m_rd_d  = cpu_wbd_stb && !cpu_wbd_we;
                busy    = m_in_frame;
                if (cpu_wbd_stb) begin
                    if (!cpu_wbd_addr[31]) begin
                        widx = int'((cpu_wbd_addr >> 2) % DW);
                        if (cpu_wbd_we) begin
                            for (int b = 0; b < 4; b++)
                                if (cpu_wbd_be[b]) m_ram[widx][8*b +: 8] = cpu_wbd_data_o[8*b +: 8];
                        end else begin
                            m_dat_d = m_ram[widx];
                        end
                    end else if (cpu_wbd_we) begin
                        if (cpu_wbd_addr == 32'h8000_0000 && cpu_wbd_be[0] && !busy) begin
                            fr = {1'b0, cpu_wbd_data_o[7:0], 1'b1};
                            for (int i = 9; i >= 0; i--) tx_q.push_back(fr[i]);
                        end
                    end else begin
                        m_dat_d = (cpu_wbd_addr == 32'h8000_0004) ? {31'b0, busy} : 32'h0;
                    end
                end
                if (tx_q.size() > 0) begin
                    m_tx       = tx_q.pop_front();
                    m_in_frame = 1'b1;
                end else begin
                    m_tx       = 1'b1;
                    m_in_frame = 1'b0;
                end
            end
        end
    end

    // Compare every cycle on the falling edge
    initial begin
        forever begin
            @(negedge sys_clk);
            if (chk_en) begin
                chk("cpu_rst_n", {31'b0, cpu_rst_n}, {31'b0, m_boot});
                chk("wbi_stall", {31'b0, cpu_wbi_stall}, {31'b0, !m_boot});
                chk("uart_tx", {31'b0, uart_tx}, {31'b0, m_tx});
                chk("wbi_ack", {31'b0, cpu_wbi_ack}, {31'b0, m_ack_i});
                chk("wbd_ack", {31'b0, cpu_wbd_ack}, {31'b0, m_ack_d});
                if (m_ack_i) chk("wbi_data", cpu_wbi_data, m_dat_i);
                if (m_ack_d && m_rd_d) chk("wbd_data_i", cpu_wbd_data_i, m_dat_d);
                if (m_in_reset) begin
                    chk("rst_wbi_data", cpu_wbi_data, 32'h0);
                    chk("rst_wbd_data", cpu_wbd_data_i, 32'h0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop, output logic rstn_at_stop);
        uart_rx = 1'b0;
        tick();
        for (int i = 7; i >= 0; i--) begin
            uart_rx = b[i];
            tick();
        end
        uart_rx = stop;
        @(negedge sys_clk);
        rstn_at_stop = cpu_rst_n;
        tick();
        uart_rx = 1'b1;
        if (stop) m_byte(b);
    endtask

    task automatic send_word(input logic [31:0] w, output logic rstn_at_stop);
        for (int j = 3; j >= 0; j--) send_byte(w[8*j +: 8], 1'b1, rstn_at_stop);
    endtask

    task automatic fetch3(input logic [31:0] a0, a1, a2, e0, e1, e2);
        logic [31:0] a[3];
        logic [31:0] e[3];
        a = '{a0, a1, a2};
        e = '{e0, e1, e2};
        cpu_wbi_cyc = 1'b1;
        cpu_wbi_stb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) cpu_wbi_addr = a[i];
            else begin
                cpu_wbi_cyc = 1'b0;
                cpu_wbi_stb = 1'b0;
            end
            if (i > 0) begin
                @(negedge sys_clk);
                chk("fetch_ack", {31'b0, cpu_wbi_ack}, 32'h1);
                chk("fetch_data", cpu_wbi_data, e[i-1]);
            end
            tick();
        end
    endtask

    task automatic wbd_set(input bit we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] d);
        cpu_wbd_stb    = 1'b1;
        cpu_wbd_we     = we;
        cpu_wbd_be     = be;
        cpu_wbd_addr   = a;
        cpu_wbd_data_o = d;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       r;
        logic [9:0] txv;
        sys_rst = 1'b0; uart_rx = 1'b1;
        cpu_wbi_cyc = 1'b0; cpu_wbi_stb = 1'b0; cpu_wbi_addr = '0;
        cpu_wbd_stb = 1'b0; cpu_wbd_we = 1'b0; cpu_wbd_be = '0;
        cpu_wbd_addr = '0; cpu_wbd_data_o = '0;
        repeat (3) tick();
        sys_rst = 1'b1;
        @(negedge sys_clk);
        chk("reset_rst_n", {31'b0, cpu_rst_n}, 32'h0);
        chk("reset_stall", {31'b0, cpu_wbi_stall}, 32'h1);
        chk("reset_uart_tx", {31'b0, uart_tx}, 32'h1);
        chk("reset_acks", {30'b0, cpu_wbi_ack, cpu_wbd_ack}, 32'h0);
        repeat (100) tick();
        @(negedge sys_clk);
        chk("idle_rst_n", {31'b0, cpu_rst_n}, 32'h0);

        // First image: word 0 literal, framing-error byte, then 31 more words
        send_byte(8'h00, 1'b1, r); send_byte(8'h50, 1'b1, r);
        send_byte(8'h00, 1'b1, r); send_byte(8'h93, 1'b1, r);
        send_byte(8'hC3, 1'b0, r);
        for (int i = 1; i < PW; i++) send_word(32'h2000_0000 + i, r);
        @(negedge sys_clk);
        chk("boot_a_done", {31'b0, cpu_rst_n}, 32'h1);
        send_byte(8'h77, 1'b1, r);
        fetch3(32'h0, 32'h4, 32'h8, 32'h0050_0093, 32'h2000_0001, 32'h2000_0002);

        // Reset after 2 words and part of a byte, then a full reload
        sys_rst = 1'b0; tick(); tick(); sys_rst = 1'b1; tick();
        for (int i = 0; i < 2; i++) send_word(32'h3000_0000 + i, r);
        uart_rx = 1'b0; tick();
        uart_rx = 1'b1; tick(); uart_rx = 1'b0; tick(); uart_rx = 1'b1; tick();
        sys_rst = 1'b0; tick(); tick(); sys_rst = 1'b1; tick();
        @(negedge sys_clk);
        chk("reload_rst_n_low", {31'b0, cpu_rst_n}, 32'h0);
        for (int i = 0; i < PW; i++) send_word(32'h1000_0000 + i, r);
        chk("rst_n_at_last_stop", {31'b0, r}, 32'h0);
        @(negedge sys_clk);
        chk("rst_n_after_last_stop", {31'b0, cpu_rst_n}, 32'h1);
        fetch3(32'h0, 32'h4, 32'h80, 32'h1000_0000, 32'h1000_0001, 32'h1000_0000);

        // Data RAM: byte enables, read-after-write, wrap, IO holes
        wbd_set(1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF); tick();
        wbd_set(1'b1, 4'h1, 32'h10, 32'h0000_0055); tick();
        wbd_set(1'b0, 4'h0, 32'h10, 32'h0); tick();
        wbd_set(1'b0, 4'h0, 32'h410, 32'h0);
        @(negedge sys_clk); chk("raw_read", cpu_wbd_data_i, 32'hDEAD_BE55); tick();
        wbd_set(1'b1, 4'hF, 32'h20, 32'hFFFF_FFFF);
        @(negedge sys_clk); chk("wrap_read", cpu_wbd_data_i, 32'hDEAD_BE55); tick();
        wbd_set(1'b1, 4'hA, 32'h20, 32'h1122_3344); tick();
        wbd_set(1'b0, 4'h0, 32'h20, 32'h0); tick();
        wbd_set(1'b1, 4'hF, 32'h8000_0008, 32'h1234_5678);
        @(negedge sys_clk); chk("be_mask_read", cpu_wbd_data_i, 32'h11FF_33FF); tick();
        wbd_set(1'b0, 4'h0, 32'h8000_0008, 32'h0); tick();
        cpu_wbd_stb = 1'b0;
        @(negedge sys_clk); chk("io_hole_read", cpu_wbd_data_i, 32'h0); tick();

        // UART TX frame with a status read and a dropped write mid-frame
        wbd_set(1'b1, 4'h1, 32'h8000_0000, 32'h0000_00A5); tick();
        for (int k = 0; k < 10; k++) begin
            cpu_wbd_stb    = (k == 2) || (k == 4);
            cpu_wbd_we     = (k == 4);
            cpu_wbd_addr   = (k == 2) ? 32'h8000_0004 : 32'h8000_0000;
            cpu_wbd_data_o = 32'h0000_003C;
            @(negedge sys_clk);
            txv[9-k] = uart_tx;
            if (k == 3) chk("tx_status_busy", cpu_wbd_data_i, 32'h1);
            if (k == 5) chk("tx_drop_ack", {31'b0, cpu_wbd_ack}, 32'h1);
            tick();
        end
        cpu_wbd_stb = 1'b0;
        chk("tx_frame", {22'b0, txv}, 32'h0000_014B);
        repeat (3) tick();
        wbd_set(1'b0, 4'h0, 32'h8000_0004, 32'h0); tick();
        cpu_wbd_stb = 1'b0;
        @(negedge sys_clk); chk("tx_status_idle", cpu_wbd_data_i, 32'h0); tick();
        wbd_set(1'b1, 4'h2, 32'h8000_0000, 32'h0000_3C3C); tick();
        cpu_wbd_stb = 1'b0;
        repeat (15) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
